// File: rtl/jelly_ram_async_singleport_arbiter.sv
// Shares one async-read / sync-write single-port RAM among PORTS masters.
// Define JELLY_RAM_ARBITER_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority.
module jelly_ram_async_singleport_arbiter #(
  parameter int PORTS      = 4,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = 3
) (
  input  logic                          reset,
  input  logic                          clk,
  input  logic                          cke,
  input  logic [PORTS-1:0]              s_valid,
  input  logic [PORTS-1:0]              s_we,
  input  logic [PORTS*ADDR_WIDTH-1:0]   s_addr,
  input  logic [PORTS*DATA_WIDTH-1:0]   s_din,
  output logic [PORTS-1:0]              s_ready,
  output logic [PORTS-1:0]              m_ack,
  output logic [PORTS*DATA_WIDTH-1:0]   m_rdata,
  output logic                          ram_we,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]         ram_din,
  input  logic [DATA_WIDTH-1:0]         ram_dout
);

  logic                        found_s;
  logic [PTR_WIDTH-1:0]        gidx_s;
  logic [PORTS-1:0]            grant_s;
  logic [PORTS-1:0]            m_ack_q;
  logic [PORTS-1:0]            m_ack_d;
  logic [PORTS*DATA_WIDTH-1:0] m_rdata_q;
  logic [PORTS*DATA_WIDTH-1:0] m_rdata_d;

`ifdef JELLY_RAM_ARBITER_ROUND_ROBIN_EN
  logic [PTR_WIDTH-1:0] ptr_q;
  logic [PTR_WIDTH-1:0] ptr_d;

  // Round-robin search starting at ptr_q, wrapping modulo PORTS.
  always_comb begin
    found_s = 1'b0;
    gidx_s  = '0;
    ptr_d   = ptr_q;
    for (int k = 0; k < PORTS; k++) begin
      for (int i = 0; i < PORTS; i++) begin
        if (!found_s && cke && s_valid[i] && (i == ((int'(ptr_q) + k) % PORTS))) begin
          found_s = 1'b1;
          gidx_s  = PTR_WIDTH'(i);
          ptr_d   = PTR_WIDTH'((i + 1) % PORTS);
        end else begin
          found_s = found_s;
        end
      end
    end
  end

  // Pointer advances past the winner only when a grant is issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (cke) begin
      ptr_q <= ptr_d;
    end else begin
      ptr_q <= ptr_q;
    end
  end
`else
  // Fixed priority: lowest valid index wins.
  always_comb begin
    found_s = 1'b0;
    gidx_s  = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (!found_s && cke && s_valid[i]) begin
        found_s = 1'b1;
        gidx_s  = PTR_WIDTH'(i);
      end else begin
        found_s = found_s;
      end
    end
  end
`endif

  // One-hot grant decode and RAM port mux; all-zero when nothing is granted.
  always_comb begin
    grant_s  = '0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (found_s && (i == int'(gidx_s))) begin
        grant_s[i] = 1'b1;
        ram_we     = s_we[i];
        ram_addr   = s_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        ram_din    = s_din[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        grant_s[i] = 1'b0;
      end
    end
  end

  assign s_ready = grant_s;

  // Response next-state: the granted lane captures ram_dout before any write lands.
  always_comb begin
    m_ack_d   = grant_s;
    m_rdata_d = m_rdata_q;
    for (int i = 0; i < PORTS; i++) begin
      if (grant_s[i]) begin
        m_rdata_d[i*DATA_WIDTH +: DATA_WIDTH] = ram_dout;
      end else begin
        m_rdata_d[i*DATA_WIDTH +: DATA_WIDTH] = m_rdata_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Response registers; cke low freezes the ack pulse and read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ack_q   <= '0;
      m_rdata_q <= '0;
    end else if (cke) begin
      m_ack_q   <= m_ack_d;
      m_rdata_q <= m_rdata_d;
    end else begin
      m_ack_q   <= m_ack_q;
      m_rdata_q <= m_rdata_q;
    end
  end

  assign m_ack   = m_ack_q;
  assign m_rdata = m_rdata_q;

endmodule

// File: tb/tb_jelly_ram_async_singleport_arbiter.sv
// Directed bench for jelly_ram_async_singleport_arbiter with a behavioural async-read RAM.
// Works in both builds; JELLY_RAM_ARBITER_ROUND_ROBIN_EN selects the expected grant order.
module tb_jelly_ram_async_singleport_arbiter;

`ifdef JELLY_RAM_ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cke;
  logic [3:0]  s_valid;
  logic [3:0]  s_we;
  logic [23:0] s_addr;
  logic [31:0] s_din;
  logic [3:0]  s_ready;
  logic [3:0]  m_ack;
  logic [31:0] m_rdata;
  logic        ram_we;
  logic [5:0]  ram_addr;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;

  logic [7:0] mem [0:63] = '{default: 8'h00};

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
  end
  assign ram_dout = mem[ram_addr];

  jelly_ram_async_singleport_arbiter #(
    .PORTS(4), .ADDR_WIDTH(6), .DATA_WIDTH(8), .PTR_WIDTH(3)
  ) dut (
    .reset(reset), .clk(clk), .cke(cke),
    .s_valid(s_valid), .s_we(s_we), .s_addr(s_addr), .s_din(s_din),
    .s_ready(s_ready), .m_ack(m_ack), .m_rdata(m_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  typedef struct {
    logic        cke;
    logic [3:0]  valid;
    logic [3:0]  we;
    logic [23:0] addr;
    logic [31:0] din;
    logic [3:0]  rdy;
    logic        rwe;
    logic [5:0]  raddr;
    logic [7:0]  rdin;
    logic [3:0]  ack;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Single-port request; idle lanes carry junk addr/data/we that must never reach the RAM.
  task automatic add(input logic ck, input int port, input logic we, input logic [5:0] a,
                     input logic [7:0] d, input logic [3:0] rdy, input logic rwe,
                     input logic [5:0] ra, input logic [7:0] rd, input logic [3:0] ack,
                     input logic [31:0] rdata);
    vec_t v;
    v.cke = ck; v.valid = 4'h0; v.we = 4'hF;
    v.addr = {4{6'h3F}}; v.din = {4{8'hEE}};
    if (port >= 0) begin
      v.valid[port] = 1'b1;
      v.we[port] = we;
      v.addr[port*6 +: 6] = a;
      v.din[port*8 +: 8] = d;
    end
    v.rdy = rdy; v.rwe = rwe; v.raddr = ra; v.rdin = rd; v.ack = ack; v.rdata = rdata;
    vecs.push_back(v);
  endtask

  task automatic check_comb(input string tag, input logic [3:0] rdy, input logic rwe);
    chk({tag, ".s_ready"}, {28'd0, s_ready}, {28'd0, rdy});
    chk({tag, ".ram_we"}, {31'd0, ram_we}, {31'd0, rwe});
  endtask

  initial begin
    reset = 1'b1; cke = 1'b1; s_valid = 4'h0; s_we = 4'h0; s_addr = 24'h0; s_din = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset.m_ack", {28'd0, m_ack}, 32'h0);
    chk("reset.m_rdata", m_rdata, 32'h0);
    reset = 1'b0;

    //   cke port we addr   din     rdy    rwe  raddr  rdin   ack    rdata
    add(1'b1, -1, 1'b0, 6'h00, 8'h00, 4'b0000, 1'b0, 6'h00, 8'h00, 4'b0000, 32'h00000000);
    add(1'b1,  1, 1'b1, 6'h03, 8'h5A, 4'b0010, 1'b1, 6'h03, 8'h5A, 4'b0010, 32'h00000000);
    add(1'b1,  1, 1'b0, 6'h03, 8'h77, 4'b0010, 1'b0, 6'h03, 8'h77, 4'b0010, 32'h00005A00);
    add(1'b1,  2, 1'b1, 6'h07, 8'h11, 4'b0100, 1'b1, 6'h07, 8'h11, 4'b0100, 32'h00005A00);
    add(1'b1,  0, 1'b0, 6'h07, 8'h00, 4'b0001, 1'b0, 6'h07, 8'h00, 4'b0001, 32'h00005A11);
    add(1'b1,  3, 1'b1, 6'h07, 8'hC3, 4'b1000, 1'b1, 6'h07, 8'hC3, 4'b1000, 32'h11005A11);
    add(1'b0,  3, 1'b1, 6'h07, 8'h99, 4'b0000, 1'b0, 6'h00, 8'h00, 4'b1000, 32'h11005A11);
    add(1'b1,  3, 1'b0, 6'h07, 8'h00, 4'b1000, 1'b0, 6'h07, 8'h00, 4'b1000, 32'hC3005A11);
    add(1'b1,  0, 1'b1, 6'h3F, 8'hFF, 4'b0001, 1'b1, 6'h3F, 8'hFF, 4'b0001, 32'hC3005A00);
    add(1'b1,  0, 1'b0, 6'h3F, 8'h00, 4'b0001, 1'b0, 6'h3F, 8'h00, 4'b0001, 32'hC3005AFF);
    add(1'b1, -1, 1'b0, 6'h00, 8'h00, 4'b0000, 1'b0, 6'h00, 8'h00, 4'b0000, 32'hC3005AFF);

    foreach (vecs[n]) begin
      string tag;
      tag = $sformatf("vec%0d", n);
      @(negedge clk);
      cke = vecs[n].cke; s_valid = vecs[n].valid; s_we = vecs[n].we;
      s_addr = vecs[n].addr; s_din = vecs[n].din;
      #1;
      check_comb(tag, vecs[n].rdy, vecs[n].rwe);
      chk({tag, ".ram_addr"}, {26'd0, ram_addr}, {26'd0, vecs[n].raddr});
      chk({tag, ".ram_din"}, {24'd0, ram_din}, {24'd0, vecs[n].rdin});
      @(posedge clk);
      #1;
      chk({tag, ".m_ack"}, {28'd0, m_ack}, {28'd0, vecs[n].ack});
      chk({tag, ".m_rdata"}, m_rdata, vecs[n].rdata);
    end

    // Port 2 read leaves ptr at 3 with an ack pending, then reset hits.
    @(negedge clk);
    cke = 1'b1; s_valid = 4'b0100; s_we = 4'b0000; s_addr = {6'h00, 6'h07, 6'h00, 6'h00};
    #1;
    check_comb("p2read", 4'b0100, 1'b0);
    @(posedge clk);
    #1;
    chk("p2read.m_ack", {28'd0, m_ack}, 32'h4);
    chk("p2read.m_rdata", m_rdata, 32'hC3C35AFF);
    @(negedge clk);
    s_valid = 4'b0000;
    reset = 1'b1;
    #1;
    chk("midreset.m_ack", {28'd0, m_ack}, 32'h0);
    chk("midreset.m_rdata", m_rdata, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // All four ports reading continuously.
    s_valid = 4'b1111; s_we = 4'b0000; s_addr = {6'd2, 6'd1, 6'd3, 6'd0};
    for (int c = 0; c < 5; c++) begin
      logic [3:0] exp_g;
      exp_g = RR ? (4'b0001 << (c % 4)) : 4'b0001;
      #1;
      check_comb($sformatf("allvalid%0d", c), exp_g, 1'b0);
      @(posedge clk);
      #1;
      chk($sformatf("allvalid%0d.m_ack", c), {28'd0, m_ack}, {28'd0, exp_g});
      @(negedge clk);
    end
    chk("allvalid.m_rdata", m_rdata, RR ? 32'h00005A00 : 32'h00000000);

    // Freeze with write requests pending: nothing granted, nothing written, ack held.
    cke = 1'b0; s_we = 4'b1111; s_din = 32'hA1B2C3D4;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_comb($sformatf("freeze%0d", c), 4'b0000, 1'b0);
      @(posedge clk);
      #1;
      chk($sformatf("freeze%0d.m_ack", c), {28'd0, m_ack}, 32'h1);
      chk($sformatf("freeze%0d.m_rdata", c), m_rdata, RR ? 32'h00005A00 : 32'h00000000);
      @(negedge clk);
    end
    chk("freeze.mem3", {24'd0, mem[3]}, 32'h5A);
    cke = 1'b1;
    #1;
    check_comb("resume", RR ? 4'b0010 : 4'b0001, 1'b1);
    chk("resume.ram_addr", {26'd0, ram_addr}, RR ? 32'd3 : 32'd0);
    @(posedge clk);
    #1;
    chk("resume.m_ack", {28'd0, m_ack}, RR ? 32'h2 : 32'h1);

    // Idle: RAM port parked at zero, acks drop.
    @(negedge clk);
    s_valid = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_comb($sformatf("idle%0d", c), 4'b0000, 1'b0);
      chk($sformatf("idle%0d.ram_addr", c), {26'd0, ram_addr}, 32'h0);
      @(posedge clk);
      #1;
      chk($sformatf("idle%0d.m_ack", c), {28'd0, m_ack}, 32'h0);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
